// File: rtl/phy_freelist_pkg.sv
// rtl/phy_freelist_pkg.sv - shared sizing, types and lane-count helper for the physical register free list
package phy_freelist_pkg;

    localparam int PHY_REG_NUM      = 64;
    localparam int ARCH_REG_NUM     = 32;
    localparam int RENAME_WIDTH     = 2;
    localparam int COMMIT_WIDTH     = 2;
    localparam int PHY_REG_ID_WIDTH = $clog2(PHY_REG_NUM);
    localparam int ID_W             = PHY_REG_ID_WIDTH;
    localparam int INIT_FREE        = PHY_REG_NUM - ARCH_REG_NUM;

    typedef logic [ID_W-1:0] phy_id_t;
    typedef logic [ID_W:0]   freelist_ptr_t;

    function automatic freelist_ptr_t lane_count(input logic [31:0] mask);
        freelist_ptr_t n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + freelist_ptr_t'(mask[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/phy_freelist_compactor.sv
// rtl/phy_freelist_compactor.sv - exclusive prefix popcount of a lane mask: per-lane write offset and total
module freelist_compactor #(
    parameter int LANES = 2,
    parameter int CNT_W = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]            mask_i,
    output logic [LANES-1:0][CNT_W-1:0] offset_o,
    output logic [CNT_W-1:0]            total_o
);

    logic [CNT_W-1:0] acc;

    always_comb begin
        acc      = '0;
        offset_o = '0;
        for (int i = 0; i < LANES; i++) begin
            offset_o[i] = acc;
            acc         = acc + CNT_W'(mask_i[i]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/phy_freelist.sv
// rtl/phy_freelist.sv - circular free list of physical register IDs with committed-pointer flush recovery
// Optional duplicate-release detection is enabled by defining PHY_FREELIST_DUP_CHECK_EN.
module phy_freelist
    import phy_freelist_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic [RENAME_WIDTH-1:0]            rename_freelist_req,
    output logic [RENAME_WIDTH-1:0][ID_W-1:0]  freelist_rename_id,
    output logic                               freelist_rename_ready,
    output logic [ID_W:0]                      freelist_rename_free_num,
    input  logic [COMMIT_WIDTH-1:0]            commit_freelist_release,
    input  logic [COMMIT_WIDTH-1:0][ID_W-1:0]  commit_freelist_release_id,
    input  logic [COMMIT_WIDTH-1:0]            commit_freelist_retire,
    input  logic                               commit_freelist_restore,
    output logic                               freelist_err
);

    localparam int PCNT_W = $clog2(COMMIT_WIDTH + 1);
    localparam logic [ID_W+1:0] FILL_MAX = (ID_W + 2)'(PHY_REG_NUM);

    phy_id_t       entries_q [PHY_REG_NUM];
    freelist_ptr_t wptr_q, wptr_d;
    freelist_ptr_t rptr_q, rptr_d;
    freelist_ptr_t crptr_q, crptr_d;
    freelist_ptr_t count, req_num, retire_num, push_num;
    logic [COMMIT_WIDTH-1:0][PCNT_W-1:0] push_off;
    logic [PCNT_W-1:0]                   push_total;
    logic                                pop_en;
    logic [ID_W+1:0]                     fill_after_push;

    freelist_compactor #(
        .LANES (COMMIT_WIDTH)
    ) u_compactor (
        .mask_i   (commit_freelist_release),
        .offset_o (push_off),
        .total_o  (push_total)
    );

    assign count      = wptr_q - rptr_q;
    assign req_num    = lane_count(32'(rename_freelist_req));
    assign retire_num = lane_count(32'(commit_freelist_retire));
    assign push_num   = freelist_ptr_t'(push_total);

    assign freelist_rename_ready    = (req_num <= count);
    assign freelist_rename_free_num = count;
    assign pop_en                   = freelist_rename_ready && !commit_freelist_restore;
    assign fill_after_push          = {1'b0, count} + {1'b0, push_num};

    // Lanes past the free count read stale entries; rename must ignore them.
    always_comb begin
        freelist_rename_id = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            freelist_rename_id[i] = entries_q[phy_id_t'(rptr_q + freelist_ptr_t'(i))];
        end
    end

    always_comb begin
        crptr_d = crptr_q + retire_num;
        wptr_d  = wptr_q + push_num;
        rptr_d  = rptr_q;
        if (commit_freelist_restore) begin
            rptr_d = crptr_d;
        end else if (pop_en) begin
            rptr_d = rptr_q + req_num;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q  <= '0;
            crptr_q <= '0;
            wptr_q  <= freelist_ptr_t'(INIT_FREE);
            for (int k = 0; k < PHY_REG_NUM; k++) begin
                entries_q[k] <= (k < INIT_FREE) ? phy_id_t'(ARCH_REG_NUM + k) : '0;
            end
        end else begin
            rptr_q  <= rptr_d;
            crptr_q <= crptr_d;
            wptr_q  <= wptr_d;
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (commit_freelist_release[i]) begin
                    entries_q[phy_id_t'(wptr_q + freelist_ptr_t'(push_off[i]))] <= commit_freelist_release_id[i];
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fill_after_push <= FILL_MAX);
        end
    end
`endif

`ifdef PHY_FREELIST_DUP_CHECK_EN
    // in_list tracks speculative membership; cin_list is the committed view reloaded on flush.
    logic [PHY_REG_NUM-1:0] in_list_q, in_list_d;
    logic [PHY_REG_NUM-1:0] cin_list_q, cin_list_d;
    logic                   err_q;
    logic                   dup_hit;

    always_comb begin
        cin_list_d = cin_list_q;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (freelist_ptr_t'(i) < retire_num) begin
                cin_list_d[entries_q[phy_id_t'(crptr_q + freelist_ptr_t'(i))]] = 1'b0;
            end
        end
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (commit_freelist_release[i]) begin
                cin_list_d[commit_freelist_release_id[i]] = 1'b1;
            end
        end

        in_list_d = in_list_q;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (pop_en && (freelist_ptr_t'(i) < req_num)) begin
                in_list_d[freelist_rename_id[i]] = 1'b0;
            end
        end
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (commit_freelist_release[i]) begin
                in_list_d[commit_freelist_release_id[i]] = 1'b1;
            end
        end
        if (commit_freelist_restore) begin
            in_list_d = cin_list_d;
        end
    end

    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (commit_freelist_release[i] && in_list_q[commit_freelist_release_id[i]]) begin
                dup_hit = 1'b1;
            end
            for (int j = i + 1; j < COMMIT_WIDTH; j++) begin
                if (commit_freelist_release[i] && commit_freelist_release[j] &&
                    (commit_freelist_release_id[i] == commit_freelist_release_id[j])) begin
                    dup_hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
            for (int k = 0; k < PHY_REG_NUM; k++) begin
                in_list_q[k]  <= (k >= ARCH_REG_NUM);
                cin_list_q[k] <= (k >= ARCH_REG_NUM);
            end
        end else begin
            err_q      <= err_q | dup_hit;
            in_list_q  <= in_list_d;
            cin_list_q <= cin_list_d;
        end
    end

    assign freelist_err = err_q;
`else
    assign freelist_err = 1'b0;
`endif

endmodule

// File: tb/tb_phy_freelist.sv
// tb/tb_phy_freelist.sv - directed and randomized checks of phy_freelist against a queue-based free list model
module tb_phy_freelist;
    import phy_freelist_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req;
    logic [1:0][ID_W-1:0] rid;
    logic                 ready;
    logic [ID_W:0]        free_num;
    logic [1:0]           rel;
    logic [1:0][ID_W-1:0] rel_id;
    logic [1:0]           ret;
    logic                 restore;
    logic                 err;

    always #5 clk = ~clk;

    phy_freelist dut (
        .clk                        (clk),
        .rst                        (rst),
        .rename_freelist_req        (req),
        .freelist_rename_id         (rid),
        .freelist_rename_ready      (ready),
        .freelist_rename_free_num   (free_num),
        .commit_freelist_release    (rel),
        .commit_freelist_release_id (rel_id),
        .commit_freelist_retire     (ret),
        .commit_freelist_restore    (restore),
        .freelist_err               (err)
    );

    int checks = 0;
    int errors = 0;

    // Model: every ID ever pushed, in order; rd/crd are unbounded indices into it.
    int hist[$];
    int pool[$];
    int rd, crd;
    bit exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pc2(input logic [1:0] v);
        return int'(v[0]) + int'(v[1]);
    endfunction

    task automatic model_reset();
        hist.delete();
        pool.delete();
        for (int k = ARCH_REG_NUM; k < PHY_REG_NUM; k++) hist.push_back(k);
        for (int k = 0; k < ARCH_REG_NUM; k++) pool.push_back(k);
        rd = 0;
        crd = 0;
        exp_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0; rel = '0; rel_id = '0; ret = '0; restore = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #2;
    endtask

    task automatic cycle(input logic [1:0] r, input logic [1:0] rl, input int i0, input int i1,
                         input logic [1:0] rt, input logic rs);
        int  free, nreq, rcnt;
        bit  exp_ready;
        req = r; rel = rl; ret = rt; restore = rs;
        rel_id[0] = i0[ID_W-1:0];
        rel_id[1] = i1[ID_W-1:0];
        #2;
        free = hist.size() - rd;
        nreq = pc2(r);
        exp_ready = (nreq <= free);
        check("free_num", 32'(free_num), free);
        check("ready", 32'(ready), 32'(exp_ready));
        for (int i = 0; i < 2; i++) begin
            if (i < free) check($sformatf("id_lane%0d", i), 32'(rid[i]), hist[rd + i]);
        end
        check("err", 32'(err), 32'(exp_err));
        @(posedge clk);
`ifdef PHY_FREELIST_DUP_CHECK_EN
        for (int k = rd; k < hist.size(); k++) begin
            if (rl[0] && hist[k] == i0) exp_err = 1'b1;
            if (rl[1] && hist[k] == i1) exp_err = 1'b1;
        end
        if (rl == 2'b11 && i0 == i1) exp_err = 1'b1;
`endif
        rcnt = pc2(rt);
        for (int k = 0; k < rcnt; k++) pool.push_back(hist[crd + k]);
        if (rs) rd = crd + rcnt;
        else if (exp_ready) rd = rd + nreq;
        crd = crd + rcnt;
        if (rl[0]) hist.push_back(i0);
        if (rl[1]) hist.push_back(i1);
        @(negedge clk);
        #2;
    endtask

    initial begin
        int sel, avail, idx, a, b;
        logic [1:0] r, rl, rt;
        logic rs;

        rst = 1'b1;
        req = '0; rel = '0; rel_id = '0; ret = '0; restore = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state and first two-lane allocation
        check("reset_free_num", 32'(free_num), 32);
        check("reset_ready", 32'(ready), 1);
        check("reset_id0", 32'(rid[0]), 32);
        check("reset_id1", 32'(rid[1]), 33);
        check("reset_err", 32'(err), 0);
        cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        check("alloc_id0", 32'(rid[0]), 34);
        check("alloc_id1", 32'(rid[1]), 35);
        check("alloc_free_num", 32'(free_num), 30);

        // Drain to one, then a two-lane request must stall
        repeat (14) cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        cycle(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
        check("drain_free_num", 32'(free_num), 1);
        cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        check("stall_free_num", 32'(free_num), 1);
        cycle(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
        check("empty_free_num", 32'(free_num), 0);

        // Empty: release without bypass, then it becomes allocatable
        cycle(2'b01, 2'b10, 0, 5, 2'b00, 1'b0);
        check("nobypass_id0", 32'(rid[0]), 5);
        check("nobypass_ready", 32'(ready), 1);

        // Pointer wrap with steady one-in/one-out traffic
        for (int n = 0; n < 40; n++) begin
            cycle(2'b01, 2'b01, hist[crd], 0, 2'b01, 1'b0);
            check("wrap_free_num", 32'(free_num), 1);
        end

        // Flush after one retire
        do_reset();
        cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        cycle(2'b00, 2'b00, 0, 0, 2'b01, 1'b0);
        cycle(2'b00, 2'b00, 0, 0, 2'b00, 1'b1);
        check("restore_id0", 32'(rid[0]), 33);
        check("restore_free_num", 32'(free_num), 31);

        // Flush with retires in the same cycle
        do_reset();
        cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        cycle(2'b11, 2'b00, 0, 0, 2'b11, 1'b1);
        check("restore_ret_id0", 32'(rid[0]), 34);
        check("restore_ret_free_num", 32'(free_num), 30);

`ifdef PHY_FREELIST_DUP_CHECK_EN
        do_reset();
        cycle(2'b00, 2'b01, 40, 0, 2'b00, 1'b0);
        check("dup_inlist_err", 32'(err), 1);
        repeat (3) cycle(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
        check("dup_inlist_held", 32'(err), 1);
        do_reset();
        check("dup_cleared", 32'(err), 0);
        cycle(2'b00, 2'b11, 3, 3, 2'b00, 1'b0);
        check("dup_lanes_err", 32'(err), 1);
`endif

        // Randomized legal traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 2));
            r = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
            rs = ($urandom_range(0, 15) == 0);
            rt = 2'($urandom_range(0, 3));
            avail = rd - crd;
            if (avail == 0) rt = 2'b00;
            else if (avail == 1 && rt == 2'b11) rt = 2'b10;
            rl = 2'($urandom_range(0, 3));
            if (pool.size() == 0) rl = 2'b00;
            else if (pool.size() == 1 && rl == 2'b11) rl = 2'b01;
            a = 0;
            b = 0;
            if (rl[0]) begin
                idx = int'($urandom_range(0, pool.size() - 1));
                a = pool[idx];
                pool.delete(idx);
            end
            if (rl[1]) begin
                idx = int'($urandom_range(0, pool.size() - 1));
                b = pool[idx];
                pool.delete(idx);
            end
            cycle(r, rl, a, b, rt, rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phy_freelist.md
Name: phy_freelist

Overview:
- Circular FIFO of free physical register IDs.
- Feeds the rename stage: it hands out destination IDs, and those IDs later index the physical register file's write and valid logic.
- Commit returns old mappings to the FIFO.
- Keeps a committed read pointer so a pipeline flush reclaims every speculatively allocated ID in one cycle.

Parameters:
PHY_REG_NUM, 64, physical register count; power of two; FIFO depth.
ARCH_REG_NUM, 32, architectural register count; IDs 0..ARCH_REG_NUM-1 are mapped at reset.
RENAME_WIDTH, 2, allocation lanes per cycle.
COMMIT_WIDTH, 2, release/retire lanes per cycle.
ID_W, $clog2(PHY_REG_NUM), ID width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- rename_freelist_req  in  RENAME_WIDTH  allocation requests; lane-contiguous from lane 0.
- freelist_rename_id  out  RENAME_WIDTH x ID_W  lane i = entry at rptr+i; combinational peek.
- freelist_rename_ready  out  1  request count <= free count; pops happen only when high.
- freelist_rename_free_num  out  ID_W+1  current free count.
- commit_freelist_release  in  COMMIT_WIDTH  per-lane release enable; any bit pattern.
- commit_freelist_release_id  in  COMMIT_WIDTH x ID_W  IDs being freed.
- commit_freelist_retire  in  COMMIT_WIDTH  committed instruction owned an allocated dest; advances crptr.
- commit_freelist_restore  in  1  flush; rptr returns to committed pointer.
- freelist_err  out  1  sticky error (only with the optional feature; tied 0 otherwise).

Behaviour:
- Storage: PHY_REG_NUM x ID_W array.
- Pointers: wptr, rptr, crptr, each ID_W+1 bits with a wrap bit. count = wptr - rptr, modulo 2^(ID_W+1).
- Reset:
  - entries[k] = ARCH_REG_NUM+k for k < PHY_REG_NUM-ARCH_REG_NUM.
  - rptr = crptr = 0; wptr = PHY_REG_NUM-ARCH_REG_NUM.
  - Outputs: free_num = 32, ready = 1, err = 0.
- Allocation:
  - nreq = popcount(req); ready = (nreq <= count), using count from the start of the cycle.
  - When ready, rptr += nreq at the clock edge. Lane i receives freelist_rename_id[i].
  - When not ready, there is no pop; rename stalls.
  - Lanes beyond count show stale data and must be ignored.
- Release:
  - Set release lanes are compacted in lane order and written at wptr, wptr+1, ...
  - wptr += popcount(release).
  - No bypass: released IDs become allocatable the next cycle.
- Retire: crptr += popcount(retire) every cycle, independent of allocation.
- Restore (flush):
  - rptr <= crptr_next, i.e. crptr plus this cycle's retire count.
  - Allocation is suppressed that cycle.
  - Releases in the same cycle still push.
- Priority: rst > restore > normal. Push and pop in the same cycle are legal, including at count 0, where the pop is denied.
- Index wrap: all indexing is pointer[ID_W-1:0]; wrap-around is seamless.
- Overflow (count + pushes > PHY_REG_NUM) is illegal by construction; a simulation assertion fires on it.
- Latency: allocation is zero-cycle combinational; all state updates take effect on the next edge.

Optional Feature:
- Macro: PHY_FREELIST_DUP_CHECK_EN.
- Defined:
  - Adds a PHY_REG_NUM-bit in_list bitmap. Reset sets bits ARCH_REG_NUM..PHY_REG_NUM-1.
  - Pop clears the bit; push sets it.
  - freelist_err goes high and stays high until rst when either occurs:
    - a release ID is already in_list;
    - two lanes release the same ID in one cycle.
  - Restore recomputes nothing. The bitmap snapshot is a committed-bitmap copy updated on retire, loaded on restore.
- Undefined: bitmap logic is absent and freelist_err is tied 0.

Decomposition:
- Config header / shared package:
  - PHY_REG_NUM, ARCH_REG_NUM, RENAME_WIDTH, COMMIT_WIDTH, PHY_REG_ID_WIDTH.
  - typedef phy_id_t.
  - typedef freelist_ptr_t (ID_W+1 bits).
- Sub-module freelist_compactor:
  - Prefix-popcount on the release mask.
  - Produces the write offset per lane and the total push count.
  - Parameterised by COMMIT_WIDTH.

Test Plan:
- Reset, no requests -> ids 32,33; free_num=32. Then req=2'b11 -> next cycle ids 34,35, free_num=30.
- Drain to free_num=1, req=2'b11 -> ready=0, free_num stays 1. Then req=2'b01 -> pop; free_num=0.
- At free_num=0, req=2'b01 together with release id 5 on lane1 -> ready=0 this cycle. Next cycle id0=5, ready=1.
- Full wrap: 40 alloc/release pairs cycling IDs -> FIFO order preserved across the pointer wrap bit; free_num constant.
- Allocate 32,33,34,35; retire 1 -> restore -> next cycle id0=33, free_num=31. Restore with retire=2'b11 in the same cycle -> id0=34.
- DUP_CHECK_EN: release id 40 while it is still in the list -> freelist_err=1 next cycle and held until rst. Same ID on both release lanes -> err=1.
